// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with a one-word holding buffer, so that
// back-to-back words leave as one unbroken bit stream on x.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             word_done_q, word_done_d;

    logic             accept;
    logic             last_bit;
    logic             load;
    logic [WIDTH-1:0] load_word;

    // The shift register holds the bits not yet placed on x, so its head is
    // always the next bit to emit.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            word_done_q <= word_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit && !hold_full_q && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        x_valid_d   = x_valid_q;
        word_done_d = 1'b0;
        load        = 1'b0;
        load_word   = in_data;

        if (state_q == IDLE) begin
            if (accept) begin
                load = 1'b1;
            end else begin
                x_d       = 1'b0;
                x_valid_d = 1'b0;
            end
        end else if (!last_bit) begin
            shift_d     = advance(shift_q);
            x_d         = head_bit(shift_q);
            cnt_d       = cnt_q + 1'b1;
            word_done_d = (cnt_q == CW'(WIDTH - 2));
            if (accept) begin
                hold_d      = in_data;
                hold_full_d = 1'b1;
            end
        end else if (hold_full_q) begin
            load        = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
        end else if (accept) begin
            // Hold is empty and the current word ends now: bypass straight in.
            load = 1'b1;
        end else begin
            x_d       = 1'b0;
            x_valid_d = 1'b0;
            cnt_d     = '0;
        end

        if (load) begin
            shift_d   = advance(load_word);
            x_d       = head_bit(load_word);
            x_valid_d = 1'b1;
            cnt_d     = '0;
        end
    end

    always_comb begin
        in_ready  = ~hold_full_q & ~rst;
        busy      = x_valid_q | hold_full_q;
        x         = x_q;
        x_valid   = x_valid_q;
        word_done = word_done_q;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, word width in bits (legal range 2..32).
REQ-002 Parameter: MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB shifted first.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 x  output  1  registered serial bit; feeds a sequence detector's x input.
REQ-009 x_valid  output  1  registered; x carries a data bit this cycle.
REQ-010 word_done  output  1  registered; high exactly in the cycle the last bit of a word is on x.
REQ-011 busy  output  1  x_valid OR holding buffer full.

Function
REQ-012 Handshake: word SHALL be accepted at a rising edge where in_valid=1 and in_ready=1; no acceptance otherwise.
REQ-013 Storage: one shift register (WIDTH bits), one bit counter, one holding register with full flag.
REQ-014 in_ready SHALL equal NOT hold_full, and SHALL be 0 while rst=1.
REQ-015 States: IDLE (x_valid=0) and SHIFT (x_valid=1); no other states.
REQ-016 IDLE + accept: word SHALL load directly into shift register; first bit on x with x_valid=1 the cycle after acceptance (latency 1).
REQ-017 SHIFT, not last bit: one bit advances per clock, no stalls; an accepted word SHALL go to the holding register.
REQ-018 SHIFT, last bit on x, hold full: next edge SHALL move hold to shift register, clear hold_full, stay SHIFT; no gap cycle.
REQ-019 SHIFT, last bit on x, hold empty, accept same cycle: word SHALL bypass hold into shift register; no gap cycle.
REQ-020 SHIFT, last bit on x, hold empty, no accept: next state IDLE, x=0, x_valid=0.
REQ-021 In IDLE x SHALL be driven 0.
REQ-022 Bit order: MSB_FIRST=1 emits in_data[WIDTH-1] down to [0]; MSB_FIRST=0 emits [0] up to [WIDTH-1].
REQ-023 Each accepted word SHALL produce exactly WIDTH consecutive x_valid cycles; words SHALL never be dropped, duplicated or reordered.
REQ-024 word_done SHALL pulse once per word, coincident with its final bit.
REQ-025 in_data changes while in_valid=0 or in_ready=0 SHALL have no effect.

Reset
REQ-026 rst=1 at an edge SHALL set x=0, x_valid=0, word_done=0, hold_full=0, bit counter=0, state IDLE.
REQ-027 Reset mid-word SHALL discard the shifting and held words; no word_done for the aborted word.
REQ-028 rst SHALL dominate in_valid in the same cycle; no word accepted.
REQ-029 First acceptance possible in the first cycle with rst=0; in_ready=1 then.

Verification (WIDTH=8 unless stated)
REQ-030 Reset, then 8'hD0 valid 1 cycle, MSB_FIRST=1 -> x=1,1,0,1,0,0,0,0 on the 8 cycles after acceptance, x_valid=1 throughout, word_done on 8th bit only, then x=0, x_valid=0.
REQ-031 8'hDD then 8'hB6 presented back-to-back with in_valid held -> 16 contiguous x_valid cycles: 11011101 10110110; in_ready=0 from cycle after 2nd accept until 8th bit of 8'hDD; word_done twice.
REQ-032 Third word 8'hFF offered while hold full -> in_ready=0, not accepted until last bit of 1st word; then emitted contiguously after 2nd word.
REQ-033 MSB_FIRST=0, 8'h0B -> x=1,1,0,1,0,0,0,0.
REQ-034 rst pulsed after 3 bits of 8'hA5 with hold full -> next cycle x=0, x_valid=0, busy=0, in_ready=1; no word_done; later 8'h3C serializes correctly.
REQ-035 WIDTH=4, 4'hD streamed 3 times back-to-back -> x=110111011101 contiguous; downstream overlapping 1101 detector reports 3 hits.
